// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl -- four-source vectored interrupt controller for a 5-stage pipeline.
//
// Each request line is synchronised and edge-detected into a pending bit.
// When an enabled request is pending, the controller stalls fetch while the
// instructions already in EX/DM/WB retire (DRAIN). It then redirects the PC to
// the handler vector and flushes IF/ID and ID/EX (VECTOR), and waits in ISR
// until eret commits. RETURN finally redirects the PC back to the saved epc.
//
// Ports
//   clk             : clock, rising edge
//   reset           : asynchronous reset, active low
//   irq[3:0]        : asynchronous request lines, source 0 highest priority
//   ie_we/ie_wdata  : interrupt-enable register write
//   current_address : PC of the next instruction to be fetched
//   eret            : return-from-interrupt instruction committing
//   stall_if        : hold PC and IF/ID
//   flush           : clear IF/ID and ID/EX to NOP
//   pc_load         : PC loads pc_vector on the next edge
//   pc_vector       : redirect target
//   epc             : saved return address
//   int_active      : handler running
//   int_cause       : index of the serviced source
//   int_ack         : one-hot, one-cycle acknowledge
//   ie              : current interrupt-enable register
// -----------------------------------------------------------------------------
module intr_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  irq,
   input  logic        ie_we,
   input  logic [3:0]  ie_wdata,
   input  logic [15:0] current_address,
   input  logic        eret,
   output logic        stall_if,
   output logic        flush,
   output logic        pc_load,
   output logic [15:0] pc_vector,
   output logic [15:0] epc,
   output logic        int_active,
   output logic [1:0]  int_cause,
   output logic [3:0]  int_ack,
   output logic [3:0]  ie
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRAIN  = 3'd1,
      S_VECTOR = 3'd2,
      S_ISR    = 3'd3,
      S_RETURN = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [3:0]  r_s1;
   logic [3:0]  r_s2;
   logic [3:0]  r_s3;
   logic [3:0]  r_pending;
   logic [3:0]  r_ie;
   logic [1:0]  r_cause;
   logic [15:0] r_epc;
   logic [1:0]  r_drain_cnt;

   logic [3:0]  w_rise;
   logic [3:0]  w_clr;
   logic [3:0]  w_sel;
   logic [1:0]  w_low_idx;
   logic        w_take;

   // s1/s2 form the synchroniser, s3 is the previous synchronised value.
   assign w_rise = r_s2 & ~r_s3;

   // Selection uses the registered ie, so a write in the same cycle only
   // takes effect from the following edge.
   assign w_sel  = r_pending & r_ie;
   assign w_take = (r_state == S_IDLE) && (w_sel != 4'b0000);

   // Only the serviced source is acknowledged, on the edge leaving VECTOR.
   assign w_clr  = (r_state == S_VECTOR) ? (4'b0001 << r_cause) : 4'b0000;

   // Lowest set index wins: scan from the top so lower indices overwrite.
   always_comb begin
      w_low_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_sel[i]) begin
            w_low_idx = 2'(i);
         end
      end
   end

   // Synchroniser, pending and ie registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1      <= 4'b0000;
         r_s2      <= 4'b0000;
         r_s3      <= 4'b0000;
         r_pending <= 4'b0000;
         r_ie      <= 4'b0000;
      end else begin
         r_s1      <= irq;
         r_s2      <= r_s1;
         r_s3      <= r_s2;
         // A new rising edge wins over a simultaneous clear.
         r_pending <= (r_pending & ~w_clr) | w_rise;
         if (ie_we) begin
            r_ie <= ie_wdata;
         end
      end
   end

   // Cause and return address are captured only on DRAIN entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cause <= 2'b00;
         r_epc   <= 16'h0000;
      end else if (w_take) begin
         r_cause <= w_low_idx;
         r_epc   <= current_address;
      end
   end

   // DRAIN length counter: counts 0,1,2 while in DRAIN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_drain_cnt <= 2'd0;
      end else if (r_state == S_DRAIN) begin
         r_drain_cnt <= r_drain_cnt + 2'd1;
      end else begin
         r_drain_cnt <= 2'd0;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_take) w_next_state = S_DRAIN;
         S_DRAIN:  if (r_drain_cnt == 2'd2) w_next_state = S_VECTOR;
         S_VECTOR: w_next_state = S_ISR;
         S_ISR:    if (eret) w_next_state = S_RETURN;
         S_RETURN: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the state register only, so an asserted
   // reset clears them immediately.
   always_comb begin
      stall_if   = 1'b0;
      flush      = 1'b0;
      pc_load    = 1'b0;
      pc_vector  = 16'h0000;
      int_ack    = 4'b0000;
      int_active = 1'b0;
      case (r_state)
         S_DRAIN: begin
            stall_if = 1'b1;
         end
         S_VECTOR: begin
            pc_load   = 1'b1;
            flush     = 1'b1;
            pc_vector = 16'h0100 + {10'd0, r_cause, 4'h0};
            int_ack   = 4'b0001 << r_cause;
         end
         S_ISR: begin
            int_active = 1'b1;
         end
         S_RETURN: begin
            pc_load   = 1'b1;
            flush     = 1'b1;
            pc_vector = r_epc;
         end
         default: begin
         end
      endcase
   end

   assign epc       = r_epc;
   assign int_cause = r_cause;
   assign ie        = r_ie;

endmodule

// File: tb/tb_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl -- self-checking bench for intr_ctrl.
//
// The reference model describes service as a phase number counted from the
// moment an enabled request is accepted (0 idle, 1..3 drain, 4 vector,
// 5 handler, 6 return) and detects request edges from a history of sampled irq
// values. Inputs are driven on the falling edge, outputs checked on the
// falling edge after the model has advanced on the rising edge.
// -----------------------------------------------------------------------------
module tb_intr_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  irq = 4'b0000;
   logic        ie_we = 1'b0;
   logic [3:0]  ie_wdata = 4'b0000;
   logic [15:0] current_address = 16'h0000;
   logic        eret = 1'b0;
   logic        stall_if;
   logic        flush;
   logic        pc_load;
   logic [15:0] pc_vector;
   logic [15:0] epc;
   logic        int_active;
   logic [1:0]  int_cause;
   logic [3:0]  int_ack;
   logic [3:0]  ie;

   intr_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .irq             (irq),
      .ie_we           (ie_we),
      .ie_wdata        (ie_wdata),
      .current_address (current_address),
      .eret            (eret),
      .stall_if        (stall_if),
      .flush           (flush),
      .pc_load         (pc_load),
      .pc_vector       (pc_vector),
      .epc             (epc),
      .int_active      (int_active),
      .int_cause       (int_cause),
      .int_ack         (int_ack),
      .ie              (ie)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_phase;
   logic [3:0]  m_pend;
   logic [3:0]  m_ie;
   logic [1:0]  m_cause;
   logic [15:0] m_epc;
   logic [3:0]  m_hist[$];   // m_hist[n] = irq sampled n+1 edges ago

   function automatic void model_reset();
      m_phase = 0;
      m_pend  = 4'b0000;
      m_ie    = 4'b0000;
      m_cause = 2'b00;
      m_epc   = 16'h0000;
      m_hist  = '{4'b0000, 4'b0000, 4'b0000};
   endfunction

   function automatic void model_edge();
      logic [3:0] sel;
      logic [3:0] rise;
      logic [3:0] clr;
      sel  = m_pend & m_ie;
      // irq first high two edges ago, low three edges ago
      rise = m_hist[1] & ~m_hist[2];
      clr  = (m_phase == 4) ? (4'b0001 << m_cause) : 4'b0000;
      m_pend = (m_pend & ~clr) | rise;
      if (m_phase == 0) begin
         if (sel != 4'b0000) begin
            m_phase = 1;
            m_epc   = current_address;
            for (int i = 3; i >= 0; i--) begin
               if (sel[i]) m_cause = 2'(i);
            end
         end
      end else if (m_phase >= 1 && m_phase <= 4) begin
         m_phase = m_phase + 1;
      end else if (m_phase == 5) begin
         if (eret) m_phase = 6;
      end else begin
         m_phase = 0;
      end
      if (ie_we) m_ie = ie_wdata;
      m_hist.push_front(irq);
      void'(m_hist.pop_back());
   endfunction

   task automatic check_outputs(input string where);
      logic [15:0] exp_vec;
      logic [3:0]  exp_ack;
      exp_vec = 16'h0000;
      exp_ack = 4'b0000;
      if (m_phase == 4) begin
         exp_vec = 16'h0100 + 16'(m_cause) * 16'd16;
         exp_ack = 4'b0001 << m_cause;
      end else if (m_phase == 6) begin
         exp_vec = m_epc;
      end
      check({where, ".stall_if"},   32'(stall_if),   32'(m_phase >= 1 && m_phase <= 3));
      check({where, ".flush"},      32'(flush),      32'(m_phase == 4 || m_phase == 6));
      check({where, ".pc_load"},    32'(pc_load),    32'(m_phase == 4 || m_phase == 6));
      check({where, ".pc_vector"},  32'(pc_vector),  32'(exp_vec));
      check({where, ".int_ack"},    32'(int_ack),    32'(exp_ack));
      check({where, ".int_active"}, 32'(int_active), 32'(m_phase == 5));
      check({where, ".epc"},        32'(epc),        32'(m_epc));
      check({where, ".int_cause"},  32'(int_cause),  32'(m_cause));
      check({where, ".ie"},         32'(ie),         32'(m_ie));
   endtask

   // One clock: advance model on the rising edge, compare on the falling edge.
   task automatic step(input string where);
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      check_outputs(where);
   endtask

   // Assert reset mid-cycle, check the asynchronous clear, release on a later
   // falling edge.
   task automatic pulse_reset(input string where);
      reset = 1'b0;
      #1;
      model_reset();
      check({where, ".async_stall"}, 32'(stall_if), 32'd0);
      check({where, ".async_load"},  32'(pc_load),  32'd0);
      check_outputs(where);
      step(where);
      reset = 1'b1;
   endtask

   int  n_stall;
   bit  found;

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check_outputs("reset");

      // Scenario 1: single source 2 with ie=4'b0100
      ie_we = 1'b1; ie_wdata = 4'b0100; current_address = 16'h0040; irq = 4'b0100;
      step("s1");
      ie_we = 1'b0;
      n_stall = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step("s1");
         if (stall_if) n_stall++;
         if (pc_load) found = 1'b1;
      end
      check("s1.vector_reached", 32'(found), 32'd1);
      check("s1.stall_cycles", 32'(n_stall), 32'd3);
      check("s1.pc_vector", 32'(pc_vector), 32'h0120);
      check("s1.int_ack", 32'(int_ack), 32'h4);
      check("s1.epc", 32'(epc), 32'h0040);
      check("s1.int_cause", 32'(int_cause), 32'd2);
      step("s1");
      check("s1.int_active", 32'(int_active), 32'd1);
      eret = 1'b1; step("s1"); eret = 1'b0;
      irq = 4'b0000;
      repeat (4) step("s1");

      // Scenario 2: two sources together, then scenario 6 re-raise in ISR
      ie_we = 1'b1; ie_wdata = 4'hF; irq = 4'b1010; current_address = 16'h1234;
      step("s2"); ie_we = 1'b0;
      repeat (10) step("s2");
      irq = 4'b1011;  // source 0 rises while the handler is running
      repeat (6) step("s6");
      eret = 1'b1; step("s2"); eret = 1'b0;
      irq = 4'b0000;
      repeat (30) begin
         step("s2");
         if (int_active) begin eret = 1'b1; step("s2"); eret = 1'b0; end
      end

      // Scenario 3: masked request, then enable
      ie_we = 1'b1; ie_wdata = 4'h0; step("s3"); ie_we = 1'b0;
      irq = 4'b0001;
      repeat (6) step("s3");
      ie_we = 1'b1; ie_wdata = 4'h1; step("s3"); ie_we = 1'b0;
      step("s3");
      check("s3.drain_after_write", 32'(stall_if), 32'd1);

      // Scenario 5: reset during the second DRAIN cycle
      step("s5");
      pulse_reset("s5");
      irq = 4'b0000;
      repeat (6) step("s5");

      // Scenario 4: eret while idle
      eret = 1'b1; step("s4"); eret = 1'b0;
      repeat (3) step("s4");

      // Randomised traffic
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 11) == 0) irq[b] = ~irq[b];
         end
         ie_we           = ($urandom_range(0, 19) == 0);
         ie_wdata        = 4'($urandom);
         current_address = 16'($urandom);
         eret            = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 299) == 0) pulse_reset("rnd_rst");
         else step("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
